// File: rtl/inst_encoder_if.sv
// Host-side and memory-side signal bundle of the instruction encoder.
// master: host / boot loader / memory model side; slave: the encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 32
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [4:0]        in_z;
    logic [4:0]        in_a;
    logic [4:0]        in_b;
    logic [15:0]       in_imm;
    logic              in_small_imm;
    logic              in_sext;
    logic              in_negate;
    logic [2:0]        in_cc;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   count;

    modport master (
        output start, start_addr, in_valid, in_opcode, in_z, in_a, in_b,
               in_imm, in_small_imm, in_sext, in_negate, in_cc, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, error, count
    );

    modport slave (
        input  start, start_addr, in_valid, in_opcode, in_z, in_a, in_b,
               in_imm, in_small_imm, in_sext, in_negate, in_cc, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, done, error, count
    );
endinterface

// File: rtl/inst_encoder.sv
// Instruction encoder / program writer: packs decoded field bundles into
// instruction words and writes them to consecutive memory addresses.
module inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 32
) (
    input  logic          clk,
    input  logic          rst,
    inst_encoder_if.slave bus
);
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MPY  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;
    localparam logic [4:0] OP_CMP  = 5'd10;
    localparam logic [4:0] OP_MOV  = 5'd11;
    localparam logic [4:0] OP_BR   = 5'd12;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              halt_pend_q, halt_pend_d;
    logic              last_used_q, last_used_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [WIDTH-1:0]  enc_word;
    logic              op_legal;
    logic              op_halt;
    logic              in_ready;
    logic              accept;
    logic              wr_hs;
    logic              last_taken;

    // Pack the field bundle into the decoder's instruction layout.
    always_comb begin
        enc_word        = '0;
        op_legal        = 1'b1;
        op_halt         = 1'b0;
        enc_word[31:27] = bus.in_opcode;
        case (bus.in_opcode)
            OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SRL, OP_SRA, OP_CMP: begin
                enc_word[26]    = bus.in_small_imm;
                enc_word[25]    = bus.in_sext & bus.in_small_imm;
                enc_word[20:16] = bus.in_z;
                enc_word[9:5]   = bus.in_a;
                enc_word[4:0]   = bus.in_b;
                if (bus.in_opcode == OP_CMP) begin
                    enc_word[12:10] = bus.in_cc;
                end
            end
            OP_MOV: begin
                enc_word[20:16] = bus.in_z;
                enc_word[15:0]  = bus.in_imm;
            end
            OP_BR: begin
                enc_word[19]    = bus.in_negate;
                enc_word[18:16] = bus.in_a[2:0];
                enc_word[15:0]  = bus.in_imm;
                op_legal        = (bus.in_a[4:3] == 2'b00);
            end
            OP_HALT: begin
                op_halt = 1'b1;
            end
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    assign wr_hs    = mem_we_q & bus.mem_ready;
    assign in_ready = (state_q == S_RUN) & ~halt_pend_q & (~mem_we_q | bus.mem_ready);
    assign accept   = bus.in_valid & in_ready;
    // The counter saturates at the last address; that slot counts as used
    // once a word has been written there, including a write completing now.
    assign last_taken = last_used_q | (wr_hs & (addr_q == LAST_ADDR));

    // Next-state and datapath: arming, write completion, bundle acceptance.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        halt_pend_d = halt_pend_q;
        last_used_d = last_used_q;
        count_d     = count_q;
        case (state_q)
            S_RUN: begin
                if (wr_hs) begin
                    mem_we_d = 1'b0;
                    count_d  = count_q + CNT_ONE;
                    if (addr_q == LAST_ADDR) begin
                        last_used_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                    // Nothing is accepted after HALT, so a write completing
                    // while halt is pending is the HALT word itself.
                    if (halt_pend_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                if (accept) begin
                    if (!op_legal || (!op_halt && last_taken)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        mem_we_d = 1'b1;
                        wdata_d  = enc_word;
                        if (op_halt) begin
                            halt_pend_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    mem_we_d    = 1'b0;
                    addr_d      = bus.start_addr;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    halt_pend_d = 1'b0;
                    last_used_d = 1'b0;
                    count_d     = '0;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            last_used_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            halt_pend_q <= halt_pend_d;
            last_used_q <= last_used_d;
            count_q     <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_inst_encoder;
    localparam int AW   = 10;
    localparam int W    = 32;
    localparam int LAST = (1 << AW) - 1;
    localparam int NV   = 10;

    localparam logic [4:0] ADD  = 5'd1;
    localparam logic [4:0] SUB  = 5'd2;
    localparam logic [4:0] CMP  = 5'd10;
    localparam logic [4:0] MOV  = 5'd11;
    localparam logic [4:0] BR   = 5'd12;
    localparam logic [4:0] HALT = 5'd31;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(AW), .WIDTH(W)) bus ();
    inst_encoder #(.ADDR_W(AW), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    inst_encoder_if #(.ADDR_W(2), .WIDTH(W)) bus2 ();
    inst_encoder #(.ADDR_W(2), .WIDTH(W)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct {
        logic [4:0]    op, z, a, b;
        logic [15:0]   imm;
        logic          si, sx, ng;
        logic [2:0]    cc;
        logic [AW-1:0] base;
        logic [31:0]   word;
        logic          err;
    } vec_t;

    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_run, m_done, m_err, m_we, m_hp;
    int          m_base, m_k, m_count;
    logic [AW-1:0] m_addr;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [4:0] op, input logic [4:0] a);
        return (op >= 5'd1 && op <= 5'd11) || op == HALT || (op == BR && a < 5'd8);
    endfunction

    function automatic logic [31:0] ref_word(input logic [4:0] op, z, a, b,
                                             input logic [15:0] imm,
                                             input logic si, sx, ng,
                                             input logic [2:0] cc);
        logic [31:0] w;
        w = 32'(op) * 32'h0800_0000;
        if (op >= 5'd1 && op <= 5'd10) begin
            w = w + 32'(si) * 32'h0400_0000 + 32'(si & sx) * 32'h0200_0000
                  + 32'(z) * 32'd65536 + 32'(a) * 32'd32 + 32'(b);
            if (op == CMP) w = w + 32'(cc) * 32'd1024;
        end else if (op == MOV) begin
            w = w + 32'(z) * 32'd65536 + 32'(imm);
        end else if (op == BR) begin
            w = w + 32'(ng) * 32'd524288 + 32'(a % 5'd8) * 32'd65536 + 32'(imm);
        end
        return w;
    endfunction

    // One clock: check in_ready, advance the model, clock the DUT, check outputs.
    task automatic cycle();
        bit rdy, was_rst;
        int idx;
        #1;
        rdy = m_run && !m_hp && (!m_we || bus.mem_ready);
        if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        was_rst = rst;
        if (rst) begin
            m_run = 0; m_done = 0; m_err = 0; m_we = 0; m_hp = 0;
            m_count = 0; m_k = 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_run = 1; m_done = 0; m_err = 0; m_hp = 0;
                m_count = 0; m_k = 0; m_base = int'(bus.start_addr);
            end
        end else begin
            if (m_we && bus.mem_ready) begin
                m_we = 0;
                m_count++;
                if (m_data[31:27] == HALT) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
            if (bus.in_valid && rdy) begin
                idx = m_base + m_k;
                if (!ref_legal(bus.in_opcode, bus.in_a) || (bus.in_opcode != HALT && idx > LAST)) begin
                    m_err = 1;
                    m_run = 0;
                end else begin
                    m_we   = 1;
                    m_addr = AW'((idx > LAST) ? LAST : idx);
                    m_data = ref_word(bus.in_opcode, bus.in_z, bus.in_a, bus.in_b, bus.in_imm,
                                      bus.in_small_imm, bus.in_sext, bus.in_negate, bus.in_cc);
                    m_k++;
                    if (bus.in_opcode == HALT) m_hp = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("mem_we", 32'(bus.mem_we), 32'(m_we));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("error", 32'(bus.error), 32'(m_err));
        chk("count", 32'(bus.count), 32'(m_count));
        if (m_we) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk("mem_wdata", bus.mem_wdata, m_data);
        end
        if (was_rst) begin
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic drive(input logic [4:0] op, z, a, b, input logic [15:0] imm,
                         input logic si, sx, ng, input logic [2:0] cc);
        bus.in_valid     = 1'b1;
        bus.in_opcode    = op;
        bus.in_z         = z;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_imm       = imm;
        bus.in_small_imm = si;
        bus.in_sext      = sx;
        bus.in_negate    = ng;
        bus.in_cc        = cc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        bus.start = 1'b1;
        bus.start_addr = base;
        cycle();
        bus.start = 1'b0;
    endtask

    initial begin
        int r;
        vecs[0] = '{ADD,  5'd3, 5'd1, 5'd2,  16'h0,    1'b0, 1'b0, 1'b0, 3'd0, 10'h010, {ADD, 27'h0030022}, 1'b0};
        vecs[1] = '{ADD,  5'd2, 5'd7, 5'h1F, 16'h0,    1'b1, 1'b1, 1'b0, 3'd0, 10'h020, {ADD, 27'h60200FF}, 1'b0};
        vecs[2] = '{CMP,  5'd1, 5'd4, 5'd6,  16'h0,    1'b0, 1'b0, 1'b0, 3'd3, 10'h030, {CMP, 27'h0010C86}, 1'b0};
        vecs[3] = '{SUB,  5'd31,5'd0, 5'd5,  16'h0,    1'b1, 1'b0, 1'b0, 3'd0, 10'h040, {SUB, 27'h41F0005}, 1'b0};
        vecs[4] = '{MOV,  5'd5, 5'd0, 5'd0,  16'hBEEF, 1'b0, 1'b0, 1'b0, 3'd0, 10'h050, {MOV, 27'h005BEEF}, 1'b0};
        vecs[5] = '{BR,   5'd0, 5'd2, 5'd0,  16'h0010, 1'b0, 1'b0, 1'b1, 3'd0, 10'h060, {BR,  27'h00A0010}, 1'b0};
        vecs[6] = '{BR,   5'd0, 5'd9, 5'd0,  16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 10'h070, 32'h0,              1'b1};
        vecs[7] = '{5'd0, 5'd1, 5'd1, 5'd1,  16'h0,    1'b0, 1'b0, 1'b0, 3'd0, 10'h080, 32'h0,              1'b1};
        vecs[8] = '{5'd13,5'd1, 5'd1, 5'd1,  16'h0,    1'b0, 1'b0, 1'b0, 3'd0, 10'h090, 32'h0,              1'b1};
        vecs[9] = '{HALT, 5'd0, 5'd0, 5'd0,  16'h0,    1'b0, 1'b0, 1'b0, 3'd0, 10'h3FF, {HALT, 27'h0},      1'b0};

        rst = 1'b1; rst2 = 1'b1;
        bus.start = 0; bus.start_addr = '0; bus.mem_ready = 0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        bus.in_valid = 0;
        bus2.start = 0; bus2.start_addr = '0; bus2.in_valid = 0; bus2.in_opcode = '0;
        bus2.in_z = '0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_imm = '0;
        bus2.in_small_imm = 0; bus2.in_sext = 0; bus2.in_negate = 0; bus2.in_cc = '0;
        bus2.mem_ready = 0;
        cycle();
        cycle();
        rst = 1'b0; rst2 = 1'b0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            do_reset();
            do_start(vecs[i].base);
            bus.mem_ready = 1'b1;
            drive(vecs[i].op, vecs[i].z, vecs[i].a, vecs[i].b, vecs[i].imm,
                  vecs[i].si, vecs[i].sx, vecs[i].ng, vecs[i].cc);
            cycle();
            bus.in_valid = 1'b0;
            chk("tbl_we", 32'(bus.mem_we), 32'(!vecs[i].err));
            chk("tbl_error", 32'(bus.error), 32'(vecs[i].err));
            if (!vecs[i].err) begin
                chk("tbl_addr", 32'(bus.mem_addr), 32'(vecs[i].base));
                chk("tbl_wdata", bus.mem_wdata, vecs[i].word);
            end
            cycle();
            chk("tbl_count", 32'(bus.count), vecs[i].err ? 32'd0 : 32'd1);
            chk("tbl_done", 32'(bus.done), 32'(vecs[i].op == HALT && !vecs[i].err));
        end

        // Back-to-back MOV, BR, HALT
        do_reset();
        do_start(10'h100);
        bus.mem_ready = 1'b1;
        drive(MOV, 5'd5, 5'd0, 5'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        chk("b2b_addr0", 32'(bus.mem_addr), 32'h100);
        chk("b2b_data0", bus.mem_wdata, {MOV, 27'h005BEEF});
        drive(BR, 5'd0, 5'd2, 5'd0, 16'h0010, 1'b0, 1'b0, 1'b1, 3'd0);
        cycle();
        chk("b2b_addr1", 32'(bus.mem_addr), 32'h101);
        chk("b2b_data1", bus.mem_wdata, {BR, 27'h00A0010});
        drive(HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        chk("b2b_addr2", 32'(bus.mem_addr), 32'h102);
        chk("b2b_data2", bus.mem_wdata, {HALT, 27'h0});
        bus.in_valid = 1'b0;
        cycle();
        chk("b2b_done", 32'(bus.done), 32'd1);
        chk("b2b_count", 32'(bus.count), 32'd3);
        chk("b2b_ready_after", 32'(bus.in_ready), 32'd0);
        drive(ADD, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        chk("b2b_no_more_we", 32'(bus.mem_we), 32'd0);
        bus.in_valid = 1'b0;

        // Stalled write held stable for four cycles
        do_reset();
        do_start(10'h200);
        bus.mem_ready = 1'b1;
        drive(ADD, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        bus.mem_ready = 1'b0;
        drive(SUB, 5'd4, 5'd4, 5'd4, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("stall_we", 32'(bus.mem_we), 32'd1);
            chk("stall_addr", 32'(bus.mem_addr), 32'h200);
            chk("stall_data", bus.mem_wdata, {ADD, 27'h0030022});
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.mem_ready = 1'b1;
        cycle();
        chk("stall_release_count", 32'(bus.count), 32'd1);
        chk("stall_release_we", 32'(bus.mem_we), 32'd0);

        // Pending write completes although the next bundle is illegal
        do_reset();
        do_start(10'h300);
        drive(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        drive(5'd20, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        bus.in_valid = 1'b0;
        chk("err_flag", 32'(bus.error), 32'd1);
        chk("err_count", 32'(bus.count), 32'd1);
        chk("err_we", 32'(bus.mem_we), 32'd0);
        cycle();
        chk("err_sticky", 32'(bus.error), 32'd1);
        do_start(10'h040);
        chk("err_cleared", 32'(bus.error), 32'd0);
        chk("err_count_cleared", 32'(bus.count), 32'd0);

        // Reset during a stalled write drops it
        bus.mem_ready = 1'b0;
        drive(MOV, 5'd1, 5'd0, 5'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data", bus.mem_wdata, 32'd0);

        // Address overflow on a 2-bit address instance, base 3
        bus2.start = 1'b1; bus2.start_addr = 2'd3;
        cycle();
        bus2.start = 1'b0;
        bus2.mem_ready = 1'b1;
        bus2.in_valid = 1'b1; bus2.in_opcode = ADD; bus2.in_z = 5'd1;
        cycle();
        chk("ovf_we", 32'(bus2.mem_we), 32'd1);
        chk("ovf_addr", 32'(bus2.mem_addr), 32'd3);
        cycle();
        chk("ovf_error", 32'(bus2.error), 32'd1);
        chk("ovf_we_after", 32'(bus2.mem_we), 32'd0);
        chk("ovf_count", 32'(bus2.count), 32'd1);
        bus2.in_valid = 1'b0;
        cycle();
        chk("ovf_no_extra", 32'(bus2.count), 32'd1);
        bus2.start = 1'b1; bus2.start_addr = 2'd1;
        cycle();
        bus2.start = 1'b0;
        chk("ovf_rearm_error", 32'(bus2.error), 32'd0);
        chk("ovf_rearm_count", 32'(bus2.count), 32'd0);
        chk("ovf_rearm_addr", 32'(bus2.mem_addr), 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            bus.start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0)
                bus.start_addr = AW'(LAST - int'($urandom_range(0, 3)));
            else
                bus.start_addr = AW'($urandom_range(0, LAST));
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 19));
            if (r < 12)       bus.in_opcode = 5'(r + 1);
            else if (r == 12) bus.in_opcode = HALT;
            else if (r == 13) bus.in_opcode = 5'($urandom_range(0, 31));
            else              bus.in_opcode = 5'($urandom_range(1, 11));
            bus.in_z = 5'($urandom_range(0, 31));
            bus.in_a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            bus.in_b = 5'($urandom_range(0, 31));
            bus.in_imm = 16'($urandom_range(0, 65535));
            bus.in_small_imm = 1'($urandom_range(0, 1));
            bus.in_sext = 1'($urandom_range(0, 1));
            bus.in_negate = 1'($urandom_range(0, 1));
            bus.in_cc = 3'($urandom_range(0, 7));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
